uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rx_sync.sv | 30 +++
 rtl/uart_rx_core.sv | 140 ++++++++++++++
 tb/tb_uart_rx_core.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// UART_RX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
package uart_pkg;

  localparam int DATA_W_DEF = 8;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} rx_state_t;
`endif

endpackage

// File: rtl/uart_rx_sync.sv
// RXD metastability synchronizer (all flops reset to line-idle 1) plus
// falling-edge detect on the synchronized value. STAGES must be >= 2.
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic RSTn,
  input  logic din,
  output logic dout,
  output logic fall
);

  logic [STAGES-1:0] sr;
  logic              prev;

  // Shift the raw line in and keep one cycle of history for the edge detect.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      sr   <= '1;
      prev <= 1'b1;
    end else begin
      sr   <= {sr[STAGES-2:0], din};
      prev <= sr[STAGES-1];
    end
  end

  assign dout = sr[STAGES-1];
  assign fall = prev & ~sr[STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver core: start/data/stop framing driven by an external mid-bit
// bps_tick, single-entry holding register with valid/ready hand-off,
// frame_err and overrun pulses.
// Optional macro UART_RX_PARITY_EN inserts an even-parity bit after the data.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic              RXD,
  input  logic              bps_tick,
  output logic              bps_en,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  rx_state_t         state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              rxd_s;
  logic              fall;
  logic              fall_late;   // edge seen in the cycle the FSM left STOP
  logic              start_det;
  logic              par_ok;

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .RSTn (RSTn),
    .din  (RXD),
    .dout (rxd_s),
    .fall (fall)
  );

  assign start_det = fall | fall_late;

`ifdef UART_RX_PARITY_EN
  logic par_acc;
  logic par_err;
  assign par_ok = ~par_err;
`else
  assign par_ok = 1'b1;
`endif

  // Frame FSM with registered bps_en, holding register and status pulses.
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      bps_en    <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      fall_late <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_acc   <= 1'b0;
      par_err   <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      fall_late <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start_det) begin
            state  <= START;
            bps_en <= 1'b1;
          end
        end
        START: begin
          if (bps_tick) begin
            if (rxd_s) begin
              // line came back high: glitch, drop silently
              state  <= IDLE;
              bps_en <= 1'b0;
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              par_acc <= 1'b0;
`endif
            end
          end
        end
        DATA: begin
          if (bps_tick) begin
            shreg   <= {rxd_s, shreg[DATA_W-1:1]};
            bit_cnt <= bit_cnt + CNT_W'(1);
`ifdef UART_RX_PARITY_EN
            par_acc <= par_acc ^ rxd_s;
            if (bit_cnt == CNT_W'(DATA_W - 1)) state <= PARITY;
`else
            if (bit_cnt == CNT_W'(DATA_W - 1)) state <= STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bps_tick) begin
            par_err <= par_acc ^ rxd_s;
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          if (bps_tick) begin
            state     <= IDLE;
            bps_en    <= 1'b0;
            fall_late <= fall;
            if (rxd_s && par_ok) begin
              if (rx_valid && !rx_ready) begin
                overrun <= 1'b1;
              end else begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          bps_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core with a scoreboard of expected received bytes.
// Baud model: while bps_en is high, one bps_tick every 16 clks, 8 clks in.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       RSTn;
  logic       RXD;
  logic       bps_tick;
  logic       bps_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  int         ferr_cnt = 0;
  int         ovr_cnt  = 0;
  logic       valid_q  = 1'b0;
  logic       acc_q    = 1'b0;

  // snapshot taken the cycle after the stop-bit tick
  logic       s_valid, s_ferr, s_ovr, s_bps;
  logic [7:0] s_data;

  logic [3:0] tcnt;

  uart_rx_core #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .RSTn      (RSTn),
    .RXD       (RXD),
    .bps_tick  (bps_tick),
    .bps_en    (bps_en),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // baud generator model
  always @(posedge clk or negedge RSTn) begin
    if (!RSTn)        tcnt <= '0;
    else if (!bps_en) tcnt <= '0;
    else              tcnt <= tcnt + 4'd1;
  end
  assign bps_tick = bps_en && (tcnt == 4'd7);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard monitor: every new load of the holding register pops one entry
  always begin
    @(negedge clk);
    #1;
    if (rx_valid && (!valid_q || acc_q)) begin
      chk("sb_pending", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) chk("sb_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
    end
    if (frame_err) ferr_cnt++;
    if (overrun)   ovr_cnt++;
    valid_q = rx_valid;
    acc_q   = rx_valid && rx_ready;
  end

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par,
                            input logic rdy_at_stop);
    logic found;
    RXD = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RXD = d[i];
      repeat (16) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    RXD = par;
    repeat (16) @(negedge clk);
`endif
    RXD = stop;
    found = 1'b0;
    for (int k = 0; k < 24 && !found; k++) begin
      @(negedge clk);
      if (bps_tick) found = 1'b1;
    end
    chk("stop_tick_seen", {31'd0, found}, 32'd1);
    if (rdy_at_stop) rx_ready = 1'b1;
    @(negedge clk);
    if (rdy_at_stop) rx_ready = 1'b0;
    s_valid = rx_valid;
    s_data  = rx_data;
    s_ferr  = frame_err;
    s_ovr   = overrun;
    s_bps   = bps_en;
    RXD = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
    chk("drain_valid_clear", {31'd0, rx_valid}, 32'd0);
  endtask

  initial begin
    int f0, o0;
    RSTn     = 1'b0;
    RXD      = 1'b1;
    rx_ready = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {20'd0, bps_en, rx_valid, frame_err, overrun, rx_data}, 32'd0);
    repeat (2) @(negedge clk);
    RSTn = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_after_reset", {22'd0, bps_en, rx_valid, rx_data}, 32'd0);

    // good frame 0xA5
    exp_q.push_back(8'hA5);
    f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    chk("a5_valid", {31'd0, s_valid}, 32'd1);
    chk("a5_data", {24'd0, s_data}, 32'h0000_00A5);
    chk("a5_bps_en_low", {31'd0, s_bps}, 32'd0);
    chk("a5_no_ferr", ferr_cnt - f0, 32'd0);
    repeat (5) @(negedge clk);
    chk("a5_held", {23'd0, rx_valid, rx_data}, 32'h0000_01A5);
    drain();

    // 3-clk low glitch: false start
    f0 = ferr_cnt;
    RXD = 1'b0;
    repeat (3) @(negedge clk);
    RXD = 1'b1;
    repeat (5) @(negedge clk);
    chk("glitch_bps_en_raised", {31'd0, bps_en}, 32'd1);
    repeat (30) @(negedge clk);
    chk("glitch_bps_en_low", {31'd0, bps_en}, 32'd0);
    chk("glitch_no_valid", {31'd0, rx_valid}, 32'd0);
    chk("glitch_no_ferr", ferr_cnt - f0, 32'd0);

    // bad stop bit
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    chk("3c_ferr_pulse", {31'd0, s_ferr}, 32'd1);
    chk("3c_no_valid", {31'd0, s_valid}, 32'd0);
    repeat (10) @(negedge clk);
    chk("3c_ferr_single", ferr_cnt - f0, 32'd1);
    chk("3c_valid_still_low", {31'd0, rx_valid}, 32'd0);

    // overrun: 0x11 held, 0x22 dropped
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    chk("11_valid", {31'd0, s_valid}, 32'd1);
    o0 = ovr_cnt;
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    chk("ovr_pulse", {31'd0, s_ovr}, 32'd1);
    chk("ovr_data_kept", {24'd0, s_data}, 32'h0000_0011);
    chk("ovr_single", ovr_cnt - o0, 32'd1);

    // accept in the same cycle as the completion of 0x22
    exp_q.push_back(8'h22);
    o0 = ovr_cnt;
    send_frame(8'h22, 1'b1, 1'b0, 1'b1);
    chk("swap_valid", {31'd0, s_valid}, 32'd1);
    chk("swap_data", {24'd0, s_data}, 32'h0000_0022);
    chk("swap_no_ovr", ovr_cnt - o0, 32'd0);
    drain();

    // reset during data bit 4
    RXD = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RXD = 1'b0;
      repeat (16) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    chk("mid_frame_bps_en", {31'd0, bps_en}, 32'd1);
    f0 = ferr_cnt;
    RSTn = 1'b0;
    @(negedge clk);
    chk("midrst_outputs", {20'd0, bps_en, rx_valid, frame_err, overrun, rx_data}, 32'd0);
    RXD = 1'b1;
    @(negedge clk);
    RSTn = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_quiet", {30'd0, bps_en, rx_valid}, 32'd0);
    chk("midrst_no_ferr", ferr_cnt - f0, 32'd0);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    chk("5a_valid", {31'd0, s_valid}, 32'd1);
    chk("5a_data", {24'd0, s_data}, 32'h0000_005A);
    drain();

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit must be 1
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    chk("par_bad_ferr", {31'd0, s_ferr}, 32'd1);
    chk("par_bad_no_valid", {31'd0, s_valid}, 32'd0);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    chk("par_good_ferr", {31'd0, s_ferr}, 32'd0);
    chk("par_good_data", {23'd0, s_valid, s_data}, 32'h0000_0107);
    drain();
`endif

    repeat (5) @(negedge clk);
    chk("sb_empty_at_end", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
